// File: rtl/deserializer4_rx_if.sv
// Bus bundle for the 4-lane deserializer: serial side in, reassembled lane
// words, per-lane history and run-length status out.
interface deserializer4_rx_if;
  logic        serial_in;
  logic        serial_valid;
  logic        sync;
  logic [3:0]  word_out;
  logic        word_valid;
  logic [1:0]  SEL;
  logic [15:0] lane_hist;
  logic [3:0]  lane_consec;
  logic [3:0]  run_len;
  logic        consec4;

  // Serial-link side: drives the bit stream, observes the receiver outputs.
  modport master (
    output serial_in, serial_valid, sync,
    input  word_out, word_valid, SEL, lane_hist, lane_consec, run_len, consec4
  );

  // Receiver side.
  modport slave (
    input  serial_in, serial_valid, sync,
    output word_out, word_valid, SEL, lane_hist, lane_consec, run_len, consec4
  );
endinterface

// File: rtl/deserializer4_rx.sv
// 4-lane deserializer: steers accepted serial bits onto lanes 0..3, emits the
// reassembled word, keeps a 4-deep per-lane history with all-ones flags and a
// saturating consecutive-ones counter on the raw accepted stream.
module deserializer4_rx (
  input  logic             CLK,
  input  logic             RST,
  deserializer4_rx_if.slave bus
);

  logic [1:0]  sel;
  logic [2:0]  shadow;       // lanes 0..2 of the frame in progress; lane 3 arrives on completion
  logic [3:0]  word_q;
  logic        word_valid_q;
  logic [15:0] hist_q;
  logic [3:0]  consec_q;
  logic [3:0]  run_q;
  logic        consec4_q;

  logic [3:0]  new_word;
  logic [15:0] hist_next;
  logic [3:0]  consec_next;
  logic [3:0]  run_next;

  // Candidate values for a completing edge and for the run counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hist_next   = hist_q;
    consec_next = consec_q;
    new_word    = {bus.serial_in, shadow};
    for (int k = 0; k < 4; k++) begin
      hist_next[4*k +: 4] = {hist_q[4*k +: 3], new_word[k]};
      consec_next[k]      = &hist_next[4*k +: 4];
    end
    if (!bus.serial_in)       run_next = 4'd0;
    else if (run_q == 4'd15)  run_next = 4'd15;
    else                      run_next = run_q + 4'd1;
  end

  // Frame steering, word completion, history and run counter state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sel          <= 2'd0;
      shadow       <= 3'd0;
      word_q       <= 4'd0;
      word_valid_q <= 1'b0;
      hist_q       <= 16'd0;
      consec_q     <= 4'd0;
      run_q        <= 4'd0;
      consec4_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      word_valid_q <= 1'b0;
      if (bus.sync) begin
        // Realign: partial word dropped; an accepted bit starts a new frame on lane 0.
        if (bus.serial_valid) begin
          shadow <= {2'b00, bus.serial_in};
          sel    <= 2'd1;
        end else begin
          shadow <= 3'd0;
          sel    <= 2'd0;
        end
      end else if (bus.serial_valid) begin
        sel <= sel + 2'd1;
        if (sel == 2'd3) begin
          word_q       <= new_word;
          word_valid_q <= 1'b1;
          hist_q       <= hist_next;
          consec_q     <= consec_next;
        end else begin
          shadow[sel] <= bus.serial_in;
        end
      end
      if (bus.serial_valid) begin
        run_q     <= run_next;
        consec4_q <= (run_next >= 4'd4);
      end
    end
  end

  assign bus.word_out    = word_q;
  assign bus.word_valid  = word_valid_q;
  assign bus.SEL         = sel;
  assign bus.lane_hist   = hist_q;
  assign bus.lane_consec = consec_q;
  assign bus.run_len     = run_q;
  assign bus.consec4     = consec4_q;

endmodule

// File: tb/tb_deserializer4_rx.sv
// Self-checking bench for deserializer4_rx: directed scenarios plus a random
// stream, compared against a frame/word-list reference model; completed words
// go through a scoreboard queue popped by an independent monitor.
module tb_deserializer4_rx;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  deserializer4_rx_if bus ();

  deserializer4_rx dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bits of the frame in progress, list of completed words
  // (newest first), and the current count of consecutive ones.
  int         frame_len = 0;
  logic [3:0] frame_bits = 4'd0;
  logic [3:0] words[$];
  int         run = 0;
  logic [3:0] last_word = 4'd0;
  logic       exp_valid = 1'b0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] model_hist();
    logic [15:0] h = 16'd0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        if (j < words.size()) h[4*k + j] = words[j][k];
    return h;
  endfunction

  function automatic logic [3:0] model_consec();
    logic [3:0] c = 4'd0;
    for (int k = 0; k < 4; k++) begin
      c[k] = (words.size() >= 4);
      for (int j = 0; j < 4 && j < words.size(); j++)
        if (!words[j][k]) c[k] = 1'b0;
    end
    return c;
  endfunction

  task automatic model_reset();
    frame_len  = 0;
    frame_bits = 4'd0;
    words.delete();
    run        = 0;
    last_word  = 4'd0;
    exp_valid  = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".SEL"},         16'(bus.SEL),         16'(frame_len));
    check({tag, ".run_len"},     16'(bus.run_len),     16'(run));
    check({tag, ".consec4"},     16'(bus.consec4),     16'(run >= 4));
    check({tag, ".word_valid"},  16'(bus.word_valid),  16'(exp_valid));
    check({tag, ".word_out"},    16'(bus.word_out),    16'(last_word));
    check({tag, ".lane_hist"},   bus.lane_hist,        model_hist());
    check({tag, ".lane_consec"}, 16'(bus.lane_consec), 16'(model_consec()));
  endtask

  // One clock of stimulus: drive, predict the edge, then compare after it.
  task automatic step(input logic v, input logic b, input logic s);
    bus.serial_valid = v;
    bus.serial_in    = b;
    bus.sync         = s;
    exp_valid = 1'b0;
    if (s) begin
      frame_len  = v ? 1 : 0;
      frame_bits = v ? {3'b000, b} : 4'd0;
    end else if (v) begin
      frame_bits[frame_len] = b;
      frame_len++;
      if (frame_len == 4) begin
        last_word = frame_bits;
        words.push_front(frame_bits);
        if (words.size() > 4) void'(words.pop_back());
        exp_q.push_back(frame_bits);
        exp_valid = 1'b1;
        frame_len = 0;
      end
    end
    if (v) run = b ? ((run < 15) ? run + 1 : 15) : 0;
    @(posedge CLK);
    #1;
    check_all("step");
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0);
  endtask

  // Monitor: every presented word must match the oldest expected word.
  always @(negedge CLK) begin
    if (RST && bus.word_valid) begin
      if (exp_q.size() == 0) begin
        check("mon.unexpected_word", 16'(bus.word_out), 16'hFFFF);
      end else begin
        logic [3:0] w;
        w = exp_q.pop_front();
        check("mon.word_out", 16'(bus.word_out), 16'(w));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.serial_valid = 1'b0;
    bus.serial_in    = 1'b0;
    bus.sync         = 1'b0;

    // Reset held with random inputs: everything stays zero.
    for (int i = 0; i < 6; i++) begin
      bus.serial_valid = 1'($urandom);
      bus.serial_in    = 1'($urandom);
      bus.sync         = 1'($urandom);
      @(posedge CLK);
      #1;
      check_all("reset_hold");
    end
    bus.serial_valid = 1'b0;
    bus.sync         = 1'b0;
    #2 RST = 1'b1;

    // Back-to-back 1,0,1,1.
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    check("basic.word_out", 16'(bus.word_out), 16'h000D);
    check("basic.word_valid", 16'(bus.word_valid), 16'h0001);
    step(0, 0, 0);
    check("basic.pulse_end", 16'(bus.word_valid), 16'h0000);

    // Gapped stream, SEL holding during gaps.
    for (int i = 0; i < 4; i++) begin
      step(1, (i == 1) ? 1'b0 : 1'b1, 0);
      if (i < 3) for (int g = 0; g < 3; g++) step(0, 1'($urandom), 0);
    end
    check("gap.word_out", 16'(bus.word_out), 16'h000D);

    // Sync mid-frame drops the first two bits.
    step(1, 1, 0); step(1, 1, 0);
    step(1, 0, 1);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    check("sync.word_out", 16'(bus.word_out), 16'h000E);

    // Sync on the completing edge: no word, bit starts a new frame.
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    step(1, 1, 1);
    check("sync3.SEL", 16'(bus.SEL), 16'h0001);
    step(0, 0, 1);

    // Lane history and all-ones flags.
    send_word(4'b0100); send_word(4'b0110); send_word(4'b1100); send_word(4'b0101);
    check("hist.lane_consec", 16'(bus.lane_consec), 16'h0004);
    check("hist.lane2", 16'(bus.lane_hist[11:8]), 16'h000F);
    send_word(4'b0000);
    check("hist.clear", 16'(bus.lane_consec), 16'h0000);

    // Run counter up to saturation and back to zero.
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    check("run.three", 16'({bus.consec4, bus.run_len}), 16'h0003);
    step(1, 1, 0);
    check("run.four", 16'({bus.consec4, bus.run_len}), 16'h0014);
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    check("run.sat", 16'(bus.run_len), 16'h000F);
    step(1, 0, 0);
    check("run.zero", 16'({bus.consec4, bus.run_len}), 16'h0000);

    // Asynchronous reset between edges with SEL=2, run_len=5.
    step(0, 0, 1);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    check("mid.pre", 16'({bus.SEL, bus.run_len}), 16'h0025);
    bus.serial_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge CLK);
    RST = 1'b1;
    step(1, 0, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    check("mid.word_out", 16'(bus.word_out), 16'h000C);

    // Random stream with occasional sync and gaps.
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0);

    step(0, 0, 0);
    @(negedge CLK);
    check("end.pending_words", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/deserializer4_rx.md
# deserializer4_rx

Receive-side counterpart of the 4-lane serializer and consecutive-ones detector. It accepts the serial bit stream one bit per qualified clock, steers bit k of each 4-bit frame back onto lane k, and emits the reassembled word. It keeps a 4-word history per lane with per-lane all-ones flags, and runs a saturating consecutive-ones counter on the raw stream. It sits directly after the serial link and feeds downstream lane consumers.

## Interface
- No parameters; lane count 4, history depth 4, run counter 4 bits are fixed.
- CLK  input  1  sole clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial data bit.
- serial_valid  input  1  serial_in is accepted on this edge when high.
- sync  input  1  frame-align strobe; forces the current bit, or the next accepted bit, to lane 0.
- word_out  output  4  last complete word; bit k = k-th accepted bit of the frame.
- word_valid  output  1  one-cycle pulse: word_out was updated on the previous edge.
- SEL  output  2  lane index the next accepted bit is written to.
- lane_hist  output  16  per-lane history; lane_hist[4k+j] = lane k bit from the j-th most recent word (j=0 newest).
- lane_consec  output  4  lane_consec[k]=1 when lane k was 1 in all of the last 4 words.
- run_len  output  4  count of consecutive accepted 1s, saturating at 15.
- consec4  output  1  high while run_len >= 4.

## Operation
- Reset (RST low, async): SEL=0, partial-word shadow=0, word_out=0, word_valid=0, lane_hist=0, lane_consec=0, run_len=0, consec4=0. Reset mid-frame discards the partial word; the first bit after release goes to lane 0.
- Accept: serial_valid=1 at a rising edge. No accept means no state change except the word_valid clear.
- Lane steering: accepted bit is written to shadow[SEL], then SEL increments mod 4 (3→0 wrap).
- Word completion: an accept with SEL==3 completes the frame on that edge:
  - word_out <= {serial_in, shadow[2:0]}.
  - word_valid <= 1.
  - Each lane_hist lane shifts: new bit goes to j=0, j=3 is dropped.
  - lane_consec[k] <= AND of the updated 4 history bits of lane k.
- The shadow is not cleared on completion; it is overwritten bit by bit.
- word_valid is cleared on every edge that does not complete a word.
- sync=1 at an edge:
  - The partial word is discarded (shadow <= 0).
  - Without accept: SEL <= 0.
  - With accept: the bit is stored as shadow[0] and SEL <= 1.
  - sync never completes a word.
  - sync does not affect word_out, lane_hist, lane_consec, or run_len.
- Run counter, updated on accept only:
  - Bit 1: run_len <= min(run_len+1, 15).
  - Bit 0: run_len <= 0.
  - consec4 is registered and equals (next run_len >= 4), so it updates on the same edge as run_len.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: word_out, word_valid, lane_hist, and lane_consec change on the edge that accepts the 4th bit. Minimum word_valid spacing is 4 cycles.
- run_len and consec4 change on the edge that accepts the bit, so consec4 is visible the cycle after the 4th consecutive 1 is accepted.
- Gaps: serial_valid may deassert for any number of cycles mid-frame; the frame position (SEL) holds.
- Sync/accept on the completing edge (SEL==3): sync wins. No word is emitted and the bit becomes lane 0 of a new frame.

## Test plan
- Reset check: hold RST low with random inputs → all outputs 0, SEL=0. Release, then accept 1,0,1,1 back-to-back → word_out=4'b1101, word_valid high for exactly one cycle after the 4th edge, SEL=0.
- Gapped stream: same 4 bits with serial_valid low for 3 cycles between bits → identical word_out=4'b1101, a single word_valid pulse, and SEL holding during gaps.
- Sync mid-frame: accept 1,1 (SEL=2), then pulse sync with accept of 0, then accept 1,1,1 → word_out=4'b1110, one word_valid. The discarded bits never appear.
- Lane history: send words 4'b0100, 4'b0110, 4'b1100, 4'b0101 → lane_consec=4'b0100 after the 4th word; lane_hist lane 2 = 4'b1111. A fifth word 4'b0000 → lane_consec=0.
- Run counter: accept 1,1,1 → consec4=0, run_len=3. A 4th 1 → consec4=1, run_len=4. Twelve more 1s → run_len=15, saturated. A 0 → run_len=0, consec4=0.
- Reset mid-operation: assert RST asynchronously between edges with SEL=2 and run_len=5 → outputs clear immediately. After release, accept 0,0,1,1 → word_out=4'b1100, and no stale bits appear.
